// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and widths: data/PC width, instruction width, NOP word, fetch FSM states.
package cpu_pkg;

    localparam int WIDTH            = 16;
    localparam int INSTRUCTIONWIDTH = 24;

    localparam logic [INSTRUCTIONWIDTH-1:0] NOP = '0;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry park register for a fetched word decode could not take; data visible the cycle after load.
// No backpressure of its own: clear wins over load, and the owner only loads when the entry is free.
module fetch_hold_buffer
    import cpu_pkg::*;
#(
    parameter int WIDTH            = cpu_pkg::WIDTH,
    parameter int INSTRUCTIONWIDTH = cpu_pkg::INSTRUCTIONWIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic                        clear,
    input  logic [INSTRUCTIONWIDTH-1:0] load_instr,
    input  logic [WIDTH-1:0]            load_pc,
    output logic                        valid,
    output logic [INSTRUCTIONWIDTH-1:0] instr,
    output logic [WIDTH-1:0]            pc
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid <= 1'b0;
            instr <= INSTRUCTIONWIDTH'(NOP);
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            instr <= INSTRUCTIONWIDTH'(NOP);
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch stage feeding IF/ID; a response reaches InstructionD one clock later when unstalled.
// stallF freezes IF/ID and parks one response in HOLD (no requests); optional counters under CPU_FETCH_PERF_EN.
module cpu_fetch
    import cpu_pkg::*;
#(
    parameter int               WIDTH            = cpu_pkg::WIDTH,
    parameter int               INSTRUCTIONWIDTH = cpu_pkg::INSTRUCTIONWIDTH,
    parameter logic [WIDTH-1:0] RESETPC          = 16'd0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        PCSelectorF,
    input  logic [WIDTH-1:0]            branchTargetF,
    input  logic                        stallF,
    output logic                        imemRequest,
    output logic [WIDTH-1:0]            imemAddress,
    input  logic                        imemReady,
    input  logic [INSTRUCTIONWIDTH-1:0] imemData,
    output logic [INSTRUCTIONWIDTH-1:0] InstructionD,
    output logic [WIDTH-1:0]            PCD,
    output logic                        validD
`ifdef CPU_FETCH_PERF_EN
    ,
    output logic [15:0]                 fetchCountF,
    output logic [15:0]                 stallCountF
`endif
);

    fetch_state_t                state;
    fetch_state_t                state_next;
    logic [WIDTH-1:0]            pc;
    logic [WIDTH-1:0]            pc_inc;
    logic                        response;
    logic                        hold_load;
    logic                        hold_clear;
    logic                        hold_valid;
    logic [INSTRUCTIONWIDTH-1:0] hold_instr;
    logic [WIDTH-1:0]            hold_pc;

    assign pc_inc   = pc + WIDTH'(1);
    assign response = (state == FETCH) && imemReady;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (PCSelectorF) begin
            state_next = FETCH;
        end else begin
            unique case (state)
                BOOT:    state_next = FETCH;
                FETCH:   if (imemReady && stallF) state_next = HOLD;
                HOLD:    if (!stallF) state_next = FETCH;
                default: state_next = BOOT;
            endcase
        end
    end

    always_comb begin
        imemRequest = (state == FETCH);
        imemAddress = pc;
    end

    // A redirect outranks everything, including a response arriving the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= RESETPC;
        end else if (PCSelectorF) begin
            pc <= branchTargetF;
        end else if (response) begin
            pc <= pc_inc;
        end
    end

    assign hold_load  = response && stallF && !PCSelectorF;
    assign hold_clear = PCSelectorF || ((state == HOLD) && !stallF);

    fetch_hold_buffer #(
        .WIDTH            (WIDTH),
        .INSTRUCTIONWIDTH (INSTRUCTIONWIDTH)
    ) u_hold (
        .clk        (clk),
        .reset      (reset),
        .load       (hold_load),
        .clear      (hold_clear),
        .load_instr (imemData),
        .load_pc    (pc_inc),
        .valid      (hold_valid),
        .instr      (hold_instr),
        .pc         (hold_pc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            InstructionD <= INSTRUCTIONWIDTH'(NOP);
            PCD          <= '0;
            validD       <= 1'b0;
        end else if (PCSelectorF) begin
            InstructionD <= INSTRUCTIONWIDTH'(NOP);
            validD       <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!stallF) begin
                        if (imemReady) begin
                            InstructionD <= imemData;
                            PCD          <= pc_inc;
                            validD       <= 1'b1;
                        end else begin
                            InstructionD <= INSTRUCTIONWIDTH'(NOP);
                            validD       <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (!stallF) begin
                        InstructionD <= hold_instr;
                        PCD          <= hold_pc;
                        validD       <= hold_valid;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CPU_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetchCountF <= '0;
            stallCountF <= '0;
        end else begin
            if (response && !PCSelectorF) fetchCountF <= fetchCountF + 16'd1;
            if (stallF) stallCountF <= stallCountF + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_fetch.sv
// Randomised bench for cpu_fetch: queue-based reference model predicts each cycle, monitor compares at negedge.
module tb_cpu_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSelectorF;
    logic [15:0] branchTargetF;
    logic        stallF;
    logic        imemRequest;
    logic [15:0] imemAddress;
    logic        imemReady;
    logic [23:0] imemData;
    logic [23:0] InstructionD;
    logic [15:0] PCD;
    logic        validD;
`ifdef CPU_FETCH_PERF_EN
    logic [15:0] fetchCountF;
    logic [15:0] stallCountF;
`endif

    always #5 clk = ~clk;

    cpu_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .PCSelectorF   (PCSelectorF),
        .branchTargetF (branchTargetF),
        .stallF        (stallF),
        .imemRequest   (imemRequest),
        .imemAddress   (imemAddress),
        .imemReady     (imemReady),
        .imemData      (imemData),
        .InstructionD  (InstructionD),
        .PCD           (PCD),
        .validD        (validD)
`ifdef CPU_FETCH_PERF_EN
        ,
        .fetchCountF   (fetchCountF),
        .stallCountF   (stallCountF)
`endif
    );

    typedef struct {
        logic        req;
        logic [15:0] addr;
        logic [23:0] instr;
        logic [15:0] pcd;
        logic        vld;
        logic [15:0] fcnt;
        logic [15:0] scnt;
    } exp_t;

    typedef struct {
        logic [23:0] instr;
        logic [15:0] pcd;
    } held_t;

    exp_t        sb[$];
    held_t       held[$];
    logic [23:0] rom [256];
    int          checks = 0;
    int          passed = 0;

    // Reference model: architectural view of the fetch stage
    logic        m_known = 1'b0;
    logic        m_boot;
    logic [15:0] m_pc;
    logic [23:0] m_instr;
    logic [15:0] m_pcd;
    logic        m_vld;
    logic [15:0] m_fcnt;
    logic [15:0] m_scnt;

    function automatic logic [23:0] mem(input logic [15:0] a);
        if (a == 16'h0000) return 24'h40F0F0;
        return rom[a[7:0]] ^ {8'h00, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act === want) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    endtask

    task automatic cycle(input logic rst, input logic sel, input logic [15:0] tgt,
                         input logic stl, input logic rdy);
        exp_t  e;
        held_t h;
        @(posedge clk);
        #1;
        reset         = rst;
        PCSelectorF   = sel;
        branchTargetF = tgt;
        stallF        = stl;
        imemReady     = rdy;
        imemData      = mem(imemAddress);
        if (m_known) begin
            e.req   = !m_boot && (held.size() == 0);
            e.addr  = m_pc;
            e.instr = m_instr;
            e.pcd   = m_pcd;
            e.vld   = m_vld;
            e.fcnt  = m_fcnt;
            e.scnt  = m_scnt;
            sb.push_back(e);
        end
        if (!rst) begin
            m_known = 1'b1;
            m_boot  = 1'b1;
            m_pc    = 16'h0000;
            held.delete();
            m_instr = '0;
            m_pcd   = '0;
            m_vld   = 1'b0;
            m_fcnt  = '0;
            m_scnt  = '0;
        end else begin
            if (stl) m_scnt = m_scnt + 16'd1;
            if (sel) begin
                m_pc    = tgt;
                m_boot  = 1'b0;
                held.delete();
                m_instr = '0;
                m_vld   = 1'b0;
            end else if (m_boot) begin
                m_boot = 1'b0;
            end else if (held.size() > 0) begin
                if (!stl) begin
                    h       = held.pop_front();
                    m_instr = h.instr;
                    m_pcd   = h.pcd;
                    m_vld   = 1'b1;
                end
            end else if (rdy) begin
                m_fcnt = m_fcnt + 16'd1;
                if (!stl) begin
                    m_instr = mem(m_pc);
                    m_pcd   = m_pc + 16'd1;
                    m_vld   = 1'b1;
                end else begin
                    h.instr = mem(m_pc);
                    h.pcd   = m_pc + 16'd1;
                    held.push_back(h);
                end
                m_pc = m_pc + 16'd1;
            end else if (!stl) begin
                m_instr = '0;
                m_vld   = 1'b0;
            end
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("validD", {31'd0, validD}, {31'd0, e.vld});
                check("InstructionD", {8'd0, InstructionD}, {8'd0, e.instr});
                check("PCD", {16'd0, PCD}, {16'd0, e.pcd});
                check("imemRequest", {31'd0, imemRequest}, {31'd0, e.req});
                if (e.req) check("imemAddress", {16'd0, imemAddress}, {16'd0, e.addr});
`ifdef CPU_FETCH_PERF_EN
                check("fetchCountF", {16'd0, fetchCountF}, {16'd0, e.fcnt});
                check("stallCountF", {16'd0, stallCountF}, {16'd0, e.scnt});
`endif
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 24'($urandom);
        reset = 1'b0; PCSelectorF = 1'b0; branchTargetF = '0;
        stallF = 1'b0; imemReady = 1'b0; imemData = '0;

        // reset, boot, first fetch at 0 and streaming
        cycle(0, 0, 16'h0, 0, 1);
        cycle(0, 0, 16'h0, 0, 1);
        for (int i = 0; i < 6; i++) cycle(1, 0, 16'h0, 0, 1);
        // redirect to 5, park its response for three stall cycles, then resume
        cycle(1, 1, 16'h0005, 0, 1);
        cycle(1, 0, 16'h0, 1, 1);
        cycle(1, 0, 16'h0, 1, 1);
        cycle(1, 0, 16'h0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 16'h0, 0, 1);
        // redirect while parked in HOLD drops the parked word
        cycle(1, 0, 16'h0, 1, 1);
        cycle(1, 0, 16'h0, 1, 0);
        cycle(1, 1, 16'h0020, 1, 1);
        for (int i = 0; i < 3; i++) cycle(1, 0, 16'h0, 0, 1);
        // PC wrap at FFFF
        cycle(1, 1, 16'hFFFF, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 16'h0, 0, 1);
        // bubbles and stalls without responses
        cycle(1, 0, 16'h0, 0, 0);
        cycle(1, 0, 16'h0, 1, 0);
        cycle(1, 0, 16'h0, 0, 1);
        // reset while holding a parked word
        cycle(1, 0, 16'h0, 1, 1);
        cycle(0, 0, 16'h0, 1, 1);
        for (int i = 0; i < 4; i++) cycle(1, 0, 16'h0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(99) != 0), ($urandom_range(9) == 0), 16'($urandom),
                  ($urandom_range(2) == 0), ($urandom_range(2) != 0));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
